// File: rtl/decode2_issue_queue.sv
// Issue queue between decode stage 2 and address generation: a circular buffer of
// decoded bundles with a precomputed sequential next EIP per entry.
module decode2_issue_queue #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned EIP_W     = 32,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [EIP_W-1:0]             in_eip,
  input  logic [15:0]                  in_cs,
  input  logic [LEN_W-1:0]             in_len,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [EIP_W-1:0]             out_eip,
  output logic [EIP_W-1:0]             out_next_eip,
  output logic [15:0]                  out_cs,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         len_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PAYLOAD_W-1:0] payload_mem  [DEPTH];
  logic [EIP_W-1:0]     eip_mem      [DEPTH];
  logic [EIP_W-1:0]     next_eip_mem [DEPTH];
  logic [15:0]          cs_mem       [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             len_err_q, len_err_d;
  logic             push, pop;
  logic [EIP_W-1:0] in_next_eip;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign in_next_eip = in_eip + {{(EIP_W-LEN_W){1'b0}}, in_len};

  // Flush wins over any push or pop in the same cycle; len_err survives it.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    len_err_d = len_err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
    if (push && (in_len == '0)) len_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      len_err_q <= len_err_d;
    end
  end

  // Storage carries no reset; entries are only observable once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      payload_mem[wr_ptr_q]  <= in_payload;
      eip_mem[wr_ptr_q]      <= in_eip;
      next_eip_mem[wr_ptr_q] <= in_next_eip;
      cs_mem[wr_ptr_q]       <= in_cs;
    end
  end

  assign out_payload  = payload_mem[rd_ptr_q];
  assign out_eip      = eip_mem[rd_ptr_q];
  assign out_next_eip = next_eip_mem[rd_ptr_q];
  assign out_cs       = cs_mem[rd_ptr_q];
  assign count        = count_q;
  assign len_err      = len_err_q;

endmodule
